// File: rtl/camera_capture.sv
// Camera byte-stream capture: packs RGB565 bytes into 128-bit SDRAM words and rotates six frame buffers.
// Optional macro CAMERA_FRAME_CHECK_EN enables the sticky per-frame word-count check on frame_error.
module camera_capture #(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int FRAME_WORDS = H_PIXELS * V_LINES / 8
) (
    input  logic         clk_25M,
    input  logic         rst_n_25M,
    input  logic         cam_vsync,
    input  logic         cam_href,
    input  logic [7:0]   cam_data,
    output logic         camera_wr_req,
    output logic [127:0] camera_data,
    output logic [24:0]  wr_address,
    output logic [2:0]   last_frame,
    output logic         frame_done,
    output logic         frame_error
);
    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {WAIT_VSYNC, SYNC, CAPTURE} state_t;

    function automatic logic [24:0] frame_base(input logic [2:0] f);
        case (f)
            3'd0:    return 25'h70800;
            3'd1:    return 25'h96000;
            3'd2:    return 25'hBB800;
            3'd3:    return 25'h00000;
            3'd4:    return 25'h25800;
            3'd5:    return 25'h4B000;
            default: return 25'h00000;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                vsync_q, vsync_d;
    logic                phase_q, phase_d;
    logic [7:0]          pix_lo_q, pix_lo_d;
    logic [2:0]          pix_cnt_q, pix_cnt_d;
    logic [7:0][15:0]    pix_buf_q, pix_buf_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic                wr_req_q, wr_req_d;
    logic [127:0]        data_q, data_d;
    logic [24:0]         addr_q, addr_d;
    logic [2:0]          last_frame_q, last_frame_d;
    logic                frame_done_q, frame_done_d;
    logic                vsync_rise;
    logic                word_done;

    assign vsync_rise = cam_vsync & ~vsync_q;

    always_comb begin
        state_d      = state_q;
        vsync_d      = cam_vsync;
        phase_d      = phase_q;
        pix_lo_d     = pix_lo_q;
        pix_cnt_d    = pix_cnt_q;
        pix_buf_d    = pix_buf_q;
        word_idx_d   = word_idx_q;
        wr_req_d     = 1'b0;
        data_d       = data_q;
        addr_d       = addr_q;
        last_frame_d = last_frame_q;
        frame_done_d = 1'b0;
        word_done    = 1'b0;
        case (state_q)
            WAIT_VSYNC: if (vsync_rise) state_d = SYNC;
            SYNC:       if (!cam_vsync) state_d = CAPTURE;
            CAPTURE: begin
                if (cam_href) begin
                    if (!phase_q) begin
                        pix_lo_d = cam_data;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d              = 1'b0;
                        pix_buf_d[pix_cnt_q] = {cam_data, pix_lo_q};
                        pix_cnt_d            = pix_cnt_q + 3'd1;
                        word_done            = (pix_cnt_q == 3'd7);
                    end
                end else begin
                    // Line ended: a dangling low byte is dropped, pixel slot kept.
                    phase_d = 1'b0;
                end
                if (word_done) begin
                    wr_req_d = 1'b1;
                    data_d   = pix_buf_d;
                    addr_d   = frame_base(last_frame_q)
                             + {{(23-IDX_W){1'b0}}, word_idx_q, 2'b00};
                    if (word_idx_q != LAST_IDX) word_idx_d = word_idx_q + IDX_W'(1);
                end
                // A word completing on the vsync edge still goes out with the old buffer.
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    last_frame_d = (last_frame_q == 3'd5) ? 3'd0 : last_frame_q + 3'd1;
                    word_idx_d   = '0;
                    pix_cnt_d    = '0;
                    phase_d      = 1'b0;
                    state_d      = SYNC;
                end
            end
            default: state_d = WAIT_VSYNC;
        endcase
    end

    always_ff @(posedge clk_25M or negedge rst_n_25M) begin
        if (!rst_n_25M) begin
            state_q      <= WAIT_VSYNC;
            vsync_q      <= 1'b0;
            phase_q      <= 1'b0;
            pix_lo_q     <= '0;
            pix_cnt_q    <= '0;
            pix_buf_q    <= '0;
            word_idx_q   <= '0;
            wr_req_q     <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            last_frame_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            phase_q      <= phase_d;
            pix_lo_q     <= pix_lo_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_buf_q    <= pix_buf_d;
            word_idx_q   <= word_idx_d;
            wr_req_q     <= wr_req_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            last_frame_q <= last_frame_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign camera_wr_req = wr_req_q;
    assign camera_data   = data_q;
    assign wr_address    = addr_q;
    assign last_frame    = last_frame_q;
    assign frame_done    = frame_done_q;

`ifdef CAMERA_FRAME_CHECK_EN
    // The index saturates, so an exact count is "last slot written once, never again".
    logic last_hit_q, last_hit_d;
    logic extra_q, extra_d;
    logic frame_error_q, frame_error_d;

    always_comb begin
        last_hit_d    = last_hit_q;
        extra_d       = extra_q;
        frame_error_d = frame_error_q;
        if (word_done && word_idx_q == LAST_IDX) begin
            if (last_hit_q) extra_d    = 1'b1;
            else            last_hit_d = 1'b1;
        end
        if (frame_done_d) begin
            if (!last_hit_d || extra_d) frame_error_d = 1'b1;
            last_hit_d = 1'b0;
            extra_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_25M or negedge rst_n_25M) begin
        if (!rst_n_25M) begin
            last_hit_q    <= 1'b0;
            extra_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            last_hit_q    <= last_hit_d;
            extra_q       <= extra_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign frame_error = frame_error_q;
`else
    assign frame_error = 1'b0;
`endif
endmodule

// File: tb/tb_camera_capture.sv
// Randomized scoreboard bench for camera_capture on a reduced 16x4 frame.
module tb_camera_capture;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int FW = H * V / 8;

    logic         clk_25M = 1'b0;
    logic         rst_n_25M = 1'b0;
    logic         cam_vsync = 1'b0;
    logic         cam_href = 1'b0;
    logic [7:0]   cam_data = 8'h00;
    logic         camera_wr_req;
    logic [127:0] camera_data;
    logic [24:0]  wr_address;
    logic [2:0]   last_frame;
    logic         frame_done;
    logic         frame_error;

    camera_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk_25M(clk_25M), .rst_n_25M(rst_n_25M),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .camera_wr_req(camera_wr_req), .camera_data(camera_data),
        .wr_address(wr_address), .last_frame(last_frame),
        .frame_done(frame_done), .frame_error(frame_error)
    );

    always #20 clk_25M = ~clk_25M;

    typedef struct { logic [127:0] d; logic [24:0] a; } word_t;
    typedef struct { logic [2:0] lf; logic err; } fd_t;
    word_t wq[$];
    fd_t   fq[$];

    int vec = 0;
    int errs = 0;

    // Reference model state
    logic [24:0] base [6];
    int          mode;
    bit          prev_v, have_lo, ferr;
    logic [7:0]  lo;
    logic [15:0] pix[$];
    int          lf, nwords;
    logic [7:0]  incr_b = 8'h01;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; prev_v = 0; have_lo = 0; ferr = 0; lf = 0; nwords = 0;
        pix.delete();
    endtask

    task automatic model(input bit v, input bit h, input logic [7:0] d);
        bit rise;
        logic [127:0] wd;
        rise   = v && !prev_v;
        prev_v = v;
        if (mode == 0) begin
            if (rise) mode = 1;
        end else if (mode == 1) begin
            if (!v) mode = 2;
        end else begin
            if (h) begin
                if (!have_lo) begin
                    lo = d; have_lo = 1;
                end else begin
                    have_lo = 0;
                    pix.push_back({d, lo});
                    if (pix.size() == 8) begin
                        for (int i = 0; i < 8; i++) wd[16*i +: 16] = pix[i];
                        wq.push_back('{wd, base[lf] + 25'(4 * ((nwords < FW) ? nwords : FW - 1))});
                        nwords++;
                        pix.delete();
                    end
                end
            end else begin
                have_lo = 0;
            end
            if (rise) begin
`ifdef CAMERA_FRAME_CHECK_EN
                if (nwords != FW) ferr = 1;
`endif
                lf = (lf + 1) % 6;
                fq.push_back('{3'(lf), ferr});
                nwords = 0; have_lo = 0; mode = 1;
                pix.delete();
            end
        end
    endtask

    task automatic cyc(input bit v, input bit h, input logic [7:0] d);
        cam_vsync = v; cam_href = h; cam_data = d;
        model(v, h, d);
        @(posedge clk_25M); #1;
    endtask

    function automatic logic [7:0] next_byte(input bit incr);
        logic [7:0] b;
        if (incr) begin
            b = incr_b;
            incr_b = incr_b + 8'd1;
        end else begin
            b = 8'($urandom);
        end
        return b;
    endfunction

    task automatic frame(input int nlines, input int odd_line, input bit coincide,
                         input int tail, input bit incr);
        int nb;
        bit v;
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00);
        for (int i = 0; i < 2; i++) cyc(0, 0, 8'h00);
        for (int l = 0; l < nlines; l++) begin
            nb = (l == odd_line) ? 2*H - 1 : 2*H;
            for (int b = 0; b < nb; b++) begin
                v = coincide && (l == nlines - 1) && (b == nb - 1);
                cyc(v, 1, next_byte(incr));
            end
            if (!(coincide && l == nlines - 1))
                for (int g = 0; g < 3; g++) cyc(0, 0, 8'h00);
        end
        for (int t = 0; t < tail; t++) cyc(0, 1, next_byte(0));
    endtask

    task automatic check_outputs_zero();
        chk("rst_wr_req",      camera_wr_req, 0);
        chk("rst_data",        camera_data,   0);
        chk("rst_address",     wr_address,    0);
        chk("rst_last_frame",  last_frame,    0);
        chk("rst_frame_done",  frame_done,    0);
        chk("rst_frame_error", frame_error,   0);
    endtask

    always @(negedge clk_25M) begin
        if (rst_n_25M) begin
            if (camera_wr_req) begin
                if (wq.size() == 0) begin
                    vec++; errs++;
                    $display("FAIL unexpected_wr_req: got data %0h addr %0h, expected no request",
                             camera_data, wr_address);
                end else begin
                    word_t w;
                    w = wq.pop_front();
                    chk("word_data", camera_data, w.d);
                    chk("word_addr", wr_address, 128'(w.a));
                end
            end
            if (frame_done) begin
                if (fq.size() == 0) begin
                    vec++; errs++;
                    $display("FAIL unexpected_frame_done: got last_frame %0d, expected no pulse", last_frame);
                end else begin
                    fd_t f;
                    f = fq.pop_front();
                    chk("last_frame", last_frame, 128'(f.lf));
                    chk("frame_error", frame_error, 128'(f.err));
                end
            end
        end
    end

    initial begin
        base = '{25'h70800, 25'h96000, 25'hBB800, 25'h00000, 25'h25800, 25'h4B000};
        model_reset();
        repeat (3) @(posedge clk_25M);
        #1;
        check_outputs_zero();
        rst_n_25M = 1'b1;

        // Bytes before the first vsync rise belong to a partial frame
        for (int i = 0; i < 20; i++) cyc(0, 1, 8'($urandom));
        frame(V, -1, 0, 0, 1);
        for (int i = 0; i < 6; i++) frame(V, -1, 0, 0, 0);
        frame(V - 1, -1, 0, 0, 0);
        frame(V, 1, 0, 0, 0);
        frame(V + 1, -1, 0, 0, 0);
        frame(V, -1, 1, 0, 0);
        frame(V, -1, 0, 5, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00);
        for (int i = 0; i < 2; i++) cyc(0, 0, 8'h00);

        // Reset in the middle of a line
        for (int i = 0; i < 11; i++) cyc(0, 1, 8'($urandom));
        @(negedge clk_25M); #1;
        rst_n_25M = 1'b0;
        cam_href = 1'b0; cam_vsync = 1'b0;
        #1;
        check_outputs_zero();
        model_reset();
        repeat (3) @(posedge clk_25M);
        #1;
        rst_n_25M = 1'b1;
        for (int i = 0; i < 10; i++) cyc(0, 1, 8'($urandom));
        frame(V, -1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00);

        chk("words_left",  wq.size(), 0);
        chk("frames_left", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
